// File: rtl/lock_pkg.sv
// Shared types and constants for the parametrised lock controller.
// State encoding is exported on the state port for the display driver.
package lock_pkg;

  localparam int TRY_W  = 4;
  localparam int TIME_W = 8;

  typedef enum logic [2:0] {
    LOCKED = 3'd0,
    ENTRY  = 3'd1,
    OPEN   = 3'd2,
    ALARM  = 3'd3
  } lock_state_e;

  // LED vector order: {red, green, alarm}
  localparam logic [2:0] LED_LOCKED = 3'b100;
  localparam logic [2:0] LED_ENTRY  = 3'b100;
  localparam logic [2:0] LED_OPEN   = 3'b010;
  localparam logic [2:0] LED_ALARM  = 3'b101;

  function automatic logic [2:0] led_of(input lock_state_e s);
    case (s)
      ENTRY:   led_of = LED_ENTRY;
      OPEN:    led_of = LED_OPEN;
      ALARM:   led_of = LED_ALARM;
      default: led_of = LED_LOCKED;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle.
// i_clr restarts the count so a fresh entry window gets a full first tick.
module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic Clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = w_wrap;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/param_lock_ctrl.sv
// Keypad lock controller: password check, entry countdown, attempt limit,
// key change and alarm lockout, with registered outputs for the display.
//
// state  | meaning
// LOCKED | idle, waiting for start
// ENTRY  | entry window running, confirm judges pw_in
// OPEN   | unlocked, confirm with pw_set rewrites the key
// ALARM  | too many failures, held until lockout timer expires
module param_lock_ctrl
  import lock_pkg::*;
#(
  parameter int              PW_W         = 8,
  parameter logic [PW_W-1:0] DEFAULT_KEY  = '0,
  parameter int              MAX_TRIES    = 3,
  parameter int              ENTRY_SECS   = 9,
  parameter int              LOCKOUT_SECS = 30,
  parameter int              TICK_DIV     = 100_000_000
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [PW_W-1:0]   pw_in,
  input  logic              start,
  input  logic              confirm,
  input  logic              pw_set,
  input  logic              lock,
  output logic              green,
  output logic              red,
  output logic              alarm,
  output logic [2:0]        state,
  output logic [TRY_W-1:0]  tries_left,
  output logic [TIME_W-1:0] time_left,
  output logic              err_pulse
);

  localparam logic [TIME_W-1:0] ENTRY_T = TIME_W'(ENTRY_SECS);
  localparam logic [TIME_W-1:0] LOCK_T  = TIME_W'(LOCKOUT_SECS);
  localparam logic [TRY_W-1:0]  MAX_T   = TRY_W'(MAX_TRIES);

  lock_state_e       r_state, w_state_nx;
  logic [PW_W-1:0]   r_key, w_key_nx;
  logic [TRY_W-1:0]  r_fail_cnt, w_fail_nx, w_fail_inc;
  logic [TIME_W-1:0] r_time_left, w_time_nx;
  logic [TRY_W-1:0]  r_tries;
  logic              r_green, r_red, r_alarm, r_err;
  logic              w_err_nx, w_clr, w_tick, w_expiry;
  logic [2:0]        w_led_nx;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .Clk    (Clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  assign w_expiry   = w_tick && (r_time_left == TIME_W'(1));
  assign w_fail_inc = (r_fail_cnt >= MAX_T) ? MAX_T : r_fail_cnt + TRY_W'(1);

  always_comb begin
    w_state_nx = r_state;
    w_key_nx   = r_key;
    w_fail_nx  = r_fail_cnt;
    w_time_nx  = r_time_left;
    w_err_nx   = 1'b0;
    w_clr      = 1'b0;
    unique case (r_state)
      LOCKED: begin
        w_time_nx = ENTRY_T;
        if (!lock && start) begin
          w_state_nx = ENTRY;
          w_clr      = 1'b1;
        end
      end
      ENTRY: begin
        if (lock) begin
          w_state_nx = LOCKED;
          w_time_nx  = ENTRY_T;
        end else if (confirm && (pw_in == r_key)) begin
          w_state_nx = OPEN;
          w_fail_nx  = '0;
          w_time_nx  = '0;
        end else if (confirm || w_expiry) begin
          // A confirm coinciding with expiry is one attempt, judged above on pw_in.
          w_err_nx  = 1'b1;
          w_fail_nx = w_fail_inc;
          if (w_fail_inc == MAX_T) begin
            w_state_nx = ALARM;
            w_time_nx  = LOCK_T;
          end else begin
            w_time_nx = ENTRY_T;
          end
        end else if (w_tick && (r_time_left != '0)) begin
          w_time_nx = r_time_left - TIME_W'(1);
        end
      end
      OPEN: begin
        w_time_nx = '0;
        if (lock) begin
          w_state_nx = LOCKED;
          w_time_nx  = ENTRY_T;
        end else if (confirm && pw_set) begin
          w_key_nx = pw_in;
        end
      end
      ALARM: begin
        if (w_tick) begin
          if (r_time_left <= TIME_W'(1)) begin
            w_state_nx = LOCKED;
            w_fail_nx  = '0;
            w_time_nx  = ENTRY_T;
          end else begin
            w_time_nx = r_time_left - TIME_W'(1);
          end
        end
      end
      default: begin
        w_state_nx = LOCKED;
        w_time_nx  = ENTRY_T;
      end
    endcase
  end

  assign w_led_nx = led_of(w_state_nx);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state     <= LOCKED;
      r_key       <= DEFAULT_KEY;
      r_fail_cnt  <= '0;
      r_time_left <= ENTRY_T;
      r_tries     <= MAX_T;
      r_red       <= 1'b1;
      r_green     <= 1'b0;
      r_alarm     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_key       <= w_key_nx;
      r_fail_cnt  <= w_fail_nx;
      r_time_left <= w_time_nx;
      r_tries     <= MAX_T - w_fail_nx;
      r_red       <= w_led_nx[2];
      r_green     <= w_led_nx[1];
      r_alarm     <= w_led_nx[0];
      r_err       <= w_err_nx;
    end
  end

  assign state      = r_state;
  assign tries_left = r_tries;
  assign time_left  = r_time_left;
  assign green      = r_green;
  assign red        = r_red;
  assign alarm      = r_alarm;
  assign err_pulse  = r_err;

endmodule

// File: tb/tb_param_lock_ctrl.sv
// Directed bench for param_lock_ctrl: a vector table for the basic flows
// plus hand sequences for alarm timeout, entry expiry and reset in ALARM.
module tb_param_lock_ctrl;

  localparam logic [2:0] S_LOCKED = 3'd0;
  localparam logic [2:0] S_ENTRY  = 3'd1;
  localparam logic [2:0] S_OPEN   = 3'd2;
  localparam logic [2:0] S_ALARM  = 3'd3;

  logic       Clk, reset;
  logic [7:0] pw_in;
  logic       start, confirm, pw_set, lock;
  logic       green, red, alarm, err_pulse;
  logic [2:0] state;
  logic [3:0] tries_left;
  logic [7:0] time_left;

  int n_checks = 0;
  int n_errors = 0;

  param_lock_ctrl #(
    .PW_W(8), .DEFAULT_KEY(8'h00), .MAX_TRIES(3),
    .ENTRY_SECS(5), .LOCKOUT_SECS(4), .TICK_DIV(4)
  ) dut (
    .Clk(Clk), .reset(reset), .pw_in(pw_in), .start(start),
    .confirm(confirm), .pw_set(pw_set), .lock(lock),
    .green(green), .red(red), .alarm(alarm), .state(state),
    .tries_left(tries_left), .time_left(time_left), .err_pulse(err_pulse)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic       st, cf, ps, lk;
    logic [7:0] pw;
    logic [2:0] es;
    logic       eg, er, ea;
    logic [3:0] etr;
    logic [7:0] etl;
    logic       eerr;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] es, input logic eg,
                         input logic er, input logic ea, input logic [3:0] etr,
                         input logic [7:0] etl, input logic eerr);
    chk({tag, " state"}, 32'(state), 32'(es));
    chk({tag, " green"}, 32'(green), 32'(eg));
    chk({tag, " red"}, 32'(red), 32'(er));
    chk({tag, " alarm"}, 32'(alarm), 32'(ea));
    chk({tag, " tries"}, 32'(tries_left), 32'(etr));
    chk({tag, " time"}, 32'(time_left), 32'(etl));
    chk({tag, " err"}, 32'(err_pulse), 32'(eerr));
  endtask

  // Drive one cycle of inputs, sample 1 time unit after the rising edge.
  task automatic step(input logic st, input logic cf, input logic ps,
                      input logic lk, input logic [7:0] pw);
    start = st; confirm = cf; pw_set = ps; lock = lk; pw_in = pw;
    @(posedge Clk);
    #1;
    start = 1'b0; confirm = 1'b0; pw_set = 1'b0; lock = 1'b0;
  endtask

  initial begin
    //            st   cf   ps   lk   pw     state     g    r    a    tries tl    err
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,8'h00, S_ENTRY, 1'b0,1'b1,1'b0,4'd3,8'd5,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, S_OPEN,  1'b1,1'b0,1'b0,4'd3,8'd0,1'b0};
    vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,8'hA5, S_OPEN,  1'b1,1'b0,1'b0,4'd3,8'd0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,8'h00, S_LOCKED,1'b0,1'b1,1'b0,4'd3,8'd5,1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,8'h00, S_ENTRY, 1'b0,1'b1,1'b0,4'd3,8'd5,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, S_ENTRY, 1'b0,1'b1,1'b0,4'd2,8'd5,1'b1};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, S_ENTRY, 1'b0,1'b1,1'b0,4'd2,8'd5,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,8'hA5, S_OPEN,  1'b1,1'b0,1'b0,4'd3,8'd0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,8'h00, S_LOCKED,1'b0,1'b1,1'b0,4'd3,8'd5,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,8'h00, S_ENTRY, 1'b0,1'b1,1'b0,4'd3,8'd5,1'b0};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,8'h11, S_ENTRY, 1'b0,1'b1,1'b0,4'd2,8'd5,1'b1};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,8'h22, S_ENTRY, 1'b0,1'b1,1'b0,4'd1,8'd5,1'b1};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b0,8'h33, S_ALARM, 1'b0,1'b1,1'b1,4'd0,8'd4,1'b1};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1,8'h00, S_ALARM, 1'b0,1'b1,1'b1,4'd0,8'd3,1'b0};
    vecs[14] = '{1'b1,1'b0,1'b0,1'b0,8'h00, S_ALARM, 1'b0,1'b1,1'b1,4'd0,8'd3,1'b0};
    vecs[15] = '{1'b0,1'b1,1'b0,1'b0,8'hA5, S_ALARM, 1'b0,1'b1,1'b1,4'd0,8'd3,1'b0};

    reset = 1'b0; start = 1'b0; confirm = 1'b0; pw_set = 1'b0; lock = 1'b0; pw_in = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    chk_out("reset", S_LOCKED, 1'b0, 1'b1, 1'b0, 4'd3, 8'd5, 1'b0);
    reset = 1'b1;
    @(posedge Clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].st, vecs[i].cf, vecs[i].ps, vecs[i].lk, vecs[i].pw);
      chk_out($sformatf("vec%0d", i), vecs[i].es, vecs[i].eg, vecs[i].er,
              vecs[i].ea, vecs[i].etr, vecs[i].etl, vecs[i].eerr);
    end

    // Alarm entered 3 edges ago with prescaler at 3; ticks land every 4th edge.
    for (int i = 1; i <= 10; i++) begin
      int e;
      e = 3 + i;
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      if (i < 10)
        chk_out($sformatf("alarm_hold%0d", i), S_ALARM, 1'b0, 1'b1, 1'b1, 4'd0,
                8'(4 - (e + 3) / 4), 1'b0);
      else
        chk_out("alarm_exit", S_LOCKED, 1'b0, 1'b1, 1'b0, 4'd3, 8'd5, 1'b0);
    end

    // Entry timeout: no confirm, countdown 5..1 then expiry counts as a failure.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_out("exp_start", S_ENTRY, 1'b0, 1'b1, 1'b0, 4'd3, 8'd5, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      if (k < 20)
        chk_out($sformatf("exp_cnt%0d", k), S_ENTRY, 1'b0, 1'b1, 1'b0, 4'd3,
                8'(5 - k / 4), 1'b0);
      else
        chk_out("exp_fire", S_ENTRY, 1'b0, 1'b1, 1'b0, 4'd2, 8'd5, 1'b1);
    end

    // Second window: correct confirm lands on the expiry cycle.
    for (int k = 21; k <= 39; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk_out($sformatf("exp2_cnt%0d", k), S_ENTRY, 1'b0, 1'b1, 1'b0, 4'd2,
              8'(5 - (k - 20) / 4), 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
    chk_out("confirm_on_expiry", S_OPEN, 1'b1, 1'b0, 1'b0, 4'd3, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_out("after_coincide", S_OPEN, 1'b1, 1'b0, 1'b0, 4'd3, 8'd0, 1'b0);

    // Reset in ALARM with a changed key restores DEFAULT_KEY.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
    chk_out("alarm2_enter", S_ALARM, 1'b0, 1'b1, 1'b1, 4'd0, 8'd4, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("alarm2_lock_ignored", 32'(state), 32'(S_ALARM));
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("alarm2_start_ignored", 32'(state), 32'(S_ALARM));
    #2 reset = 1'b0;
    #1;
    chk_out("async_reset", S_LOCKED, 1'b0, 1'b1, 1'b0, 4'd3, 8'd5, 1'b0);
    repeat (2) @(posedge Clk);
    #1 reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk_out("default_key_back", S_OPEN, 1'b1, 1'b0, 1'b0, 4'd3, 8'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
